// File: rtl/mem_stage.sv
// MIPS memory-access stage: retires ALU ops in one cycle and runs loads/stores over a
// req/ack data bus with big-endian byte lanes, stalling upstream while the bus is busy.
module mem_stage #(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        Valid,
  input  logic [31:0] Ins,
  input  logic [31:0] Result,
  input  logic [31:0] Rdata2,
  output logic        Stall,
  output logic        MemReq,
  output logic        MemWe,
  output logic [31:0] MemAddr,
  output logic [3:0]  MemBe,
  output logic [31:0] MemWdata,
  input  logic [31:0] MemRdata,
  input  logic        MemAck,
  output logic        WbValid,
  output logic [31:0] Wdata,
  output logic        Misalign,
  output logic        BusErr
);

  localparam int CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [5:0]    op_q, op_d;
  logic [1:0]    off_q, off_d;
  logic          memreq_q, memreq_d;
  logic          memwe_q, memwe_d;
  logic [31:0]   addr_q, addr_d;
  logic [3:0]    be_q, be_d;
  logic [31:0]   wdat_q, wdat_d;
  logic          wbv_q, wbv_d;
  logic [31:0]   wbdata_q, wbdata_d;
  logic          mis_q, mis_d;
  logic          berr_q, berr_d;

  // Instruction decode; only the opcode and the low address bits matter here
  logic [5:0] op;
  logic [1:0] off;
  logic       is_load, is_store, is_mem, is_half, is_word, misal;
  logic       accept_mem, timeout;
  logic       unused_ins;

  assign unused_ins = ^Ins[25:0];

  always_comb begin
    op       = Ins[31:26];
    off      = Result[1:0];
    is_load  = (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
               (op == OP_LBU) || (op == OP_LHU);
    is_store = (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    is_mem   = is_load || is_store;
    is_word  = (op == OP_LW) || (op == OP_SW);
    is_half  = (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
    misal    = (is_word && (off != 2'd0)) || (is_half && off[0]);
  end

  assign accept_mem = (state_q == S_IDLE) && Valid && is_mem && !misal;
  assign timeout    = (cnt_q == CW'(ACK_TIMEOUT - 1));

  // Store lane steering: narrow data is replicated so every enabled lane carries it
  logic [3:0]  be_new;
  logic [31:0] wdat_new;

  always_comb begin
    be_new   = 4'b1111;
    wdat_new = 32'h0;
    case (op)
      OP_SB: begin
        be_new   = 4'b1000 >> off;
        wdat_new = {4{Rdata2[7:0]}};
      end
      OP_SH: begin
        be_new   = off[1] ? 4'b0011 : 4'b1100;
        wdat_new = {2{Rdata2[15:0]}};
      end
      OP_SW:   wdat_new = Rdata2;
      default: ;
    endcase
  end

  // Load lane select and extension from the latched opcode/offset
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_val;

  always_comb begin
    case (off_q)
      2'd0:    ld_byte = MemRdata[31:24];
      2'd1:    ld_byte = MemRdata[23:16];
      2'd2:    ld_byte = MemRdata[15:8];
      default: ld_byte = MemRdata[7:0];
    endcase
    ld_half = off_q[1] ? MemRdata[15:0] : MemRdata[31:16];
    case (op_q)
      OP_LB:   ld_val = {{24{ld_byte[7]}}, ld_byte};
      OP_LBU:  ld_val = {24'h0, ld_byte};
      OP_LH:   ld_val = {{16{ld_half[15]}}, ld_half};
      OP_LHU:  ld_val = {16'h0, ld_half};
      OP_LW:   ld_val = MemRdata;
      default: ld_val = 32'h0;
    endcase
  end

  // FSM: state register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (accept_mem) state_d = S_ACCESS;
      S_ACCESS: if (MemAck || timeout) state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // FSM: outputs and datapath next-state
  always_comb begin
    Stall    = accept_mem || (state_q == S_ACCESS);
    memreq_d = (state_d == S_ACCESS);
    cnt_d    = cnt_q;
    op_d     = op_q;
    off_d    = off_q;
    memwe_d  = memwe_q;
    addr_d   = addr_q;
    be_d     = be_q;
    wdat_d   = wdat_q;
    wbv_d    = 1'b0;
    wbdata_d = wbdata_q;
    mis_d    = 1'b0;
    berr_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (Valid && !is_mem) begin
          wbv_d    = 1'b1;
          wbdata_d = Result;
        end else if (Valid && misal) begin
          wbv_d    = 1'b1;
          mis_d    = 1'b1;
          wbdata_d = 32'h0;
        end else if (accept_mem) begin
          cnt_d   = '0;
          op_d    = op;
          off_d   = off;
          memwe_d = is_store;
          addr_d  = {Result[31:2], 2'b00};
          be_d    = be_new;
          wdat_d  = wdat_new;
        end
      end
      S_ACCESS: begin
        cnt_d = cnt_q + CW'(1);
        // An ack in the final timeout cycle wins over the timeout
        if (MemAck) begin
          wbv_d    = 1'b1;
          wbdata_d = ld_val;
        end else if (timeout) begin
          wbv_d    = 1'b1;
          berr_d   = 1'b1;
          wbdata_d = 32'h0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q    <= '0;
      op_q     <= 6'h0;
      off_q    <= 2'h0;
      memreq_q <= 1'b0;
      memwe_q  <= 1'b0;
      addr_q   <= 32'h0;
      be_q     <= 4'h0;
      wdat_q   <= 32'h0;
      wbv_q    <= 1'b0;
      wbdata_q <= 32'h0;
      mis_q    <= 1'b0;
      berr_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      off_q    <= off_d;
      memreq_q <= memreq_d;
      memwe_q  <= memwe_d;
      addr_q   <= addr_d;
      be_q     <= be_d;
      wdat_q   <= wdat_d;
      wbv_q    <= wbv_d;
      wbdata_q <= wbdata_d;
      mis_q    <= mis_d;
      berr_q   <= berr_d;
    end
  end

  assign MemReq   = memreq_q;
  assign MemWe    = memwe_q;
  assign MemAddr  = addr_q;
  assign MemBe    = be_q;
  assign MemWdata = wdat_q;
  assign WbValid  = wbv_q;
  assign Wdata    = wbdata_q;
  assign Misalign = mis_q;
  assign BusErr   = berr_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios plus a randomized op stream checked
// against a lane/extension model written from the ISA rules.
module tb_mem_stage;
  localparam int TO = 16;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  logic        CLK = 1'b0;
  logic        RST, Valid, MemAck;
  logic [31:0] Ins, Result, Rdata2, MemRdata;
  logic        Stall, MemReq, MemWe, WbValid, Misalign, BusErr;
  logic [31:0] MemAddr, MemWdata, Wdata;
  logic [3:0]  MemBe;

  int errors = 0;
  int checks = 0;

  mem_stage #(.ACK_TIMEOUT(TO)) dut (
    .CLK(CLK), .RST(RST), .Valid(Valid), .Ins(Ins), .Result(Result), .Rdata2(Rdata2),
    .Stall(Stall), .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr), .MemBe(MemBe),
    .MemWdata(MemWdata), .MemRdata(MemRdata), .MemAck(MemAck), .WbValid(WbValid),
    .Wdata(Wdata), .Misalign(Misalign), .BusErr(BusErr)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic bit m_is_mem(input logic [5:0] op);
    return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW};
  endfunction

  function automatic bit m_is_store(input logic [5:0] op);
    return op inside {OP_SB, OP_SH, OP_SW};
  endfunction

  function automatic int m_size(input logic [5:0] op);
    if (op inside {OP_LB, OP_LBU, OP_SB}) return 1;
    if (op inside {OP_LH, OP_LHU, OP_SH}) return 2;
    return 4;
  endfunction

  function automatic bit m_mis(input logic [5:0] op, input int off);
    return m_is_mem(op) && (off % m_size(op) != 0);
  endfunction

  function automatic logic [3:0] m_be(input logic [5:0] op, input int off);
    if (!m_is_store(op)) return 4'hF;
    if (m_size(op) == 1) return 4'(8 >> off);
    if (m_size(op) == 2) return (off < 2) ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wd(input logic [5:0] op, input logic [31:0] d);
    logic [31:0] b, h;
    b = d & 32'hFF;
    h = d & 32'hFFFF;
    if (m_size(op) == 1) return b * 32'h01010101;
    if (m_size(op) == 2) return h * 32'h00010001;
    return d;
  endfunction

  function automatic logic [31:0] m_ld(input logic [5:0] op, input int off, input logic [31:0] rd);
    logic [31:0] v;
    if (m_size(op) == 1) begin
      v = (rd >> (8 * (3 - off))) & 32'hFF;
      if (op == OP_LB && v >= 32'h80) v = v | 32'hFFFFFF00;
      return v;
    end
    if (m_size(op) == 2) begin
      v = (rd >> ((off >= 2) ? 0 : 16)) & 32'hFFFF;
      if (op == OP_LH && v >= 32'h8000) v = v | 32'hFFFF0000;
      return v;
    end
    return rd;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic present(input logic [5:0] op, input logic [31:0] res, input logic [31:0] d2);
    logic [31:0] r;
    r      = $urandom;
    Valid  = 1'b1;
    Ins    = {op, r[25:0]};
    Result = res;
    Rdata2 = d2;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    RST = 1'b1; Valid = 1'b0; Ins = 32'h0; Result = 32'h0; Rdata2 = 32'h0;
    MemAck = 1'b0; MemRdata = 32'h0;
    #3;
    checks++;
    if ({Stall, MemReq, MemWe, MemAddr, MemBe, MemWdata, WbValid, Wdata, Misalign, BusErr} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got req=%b we=%b addr=%h be=%b wd=%h wbv=%b wdata=%h mis=%b berr=%b stall=%b, want all 0",
               MemReq, MemWe, MemAddr, MemBe, MemWdata, WbValid, Wdata, Misalign, BusErr, Stall);
    end
    tick(); tick();
    RST = 1'b0;
    tick();
    checks++;
    if ({Stall, MemReq, WbValid} !== 3'b0) begin
      errors++;
      $display("FAIL post_reset_idle: stall=%b req=%b wbv=%b want 0", Stall, MemReq, WbValid);
    end
  endtask

  task automatic test_alu_stream();
    logic [31:0] vals [3];
    vals = '{32'd5, 32'd7, 32'd9};
    for (int i = 0; i < 3; i++) begin
      present(6'h00, vals[i], 32'h0);
      #1;
      checks++;
      if (Stall !== 1'b0) begin
        errors++; $display("FAIL alu_stall[%0d]: got %b want 0", i, Stall);
      end
      tick();
      checks++;
      if ({WbValid, Misalign, BusErr, MemReq, Wdata} !== {4'b1000, vals[i]}) begin
        errors++;
        $display("FAIL alu_retire[%0d]: wbv=%b mis=%b berr=%b req=%b wdata=%h, want 1/0/0/0 %h",
                 i, WbValid, Misalign, BusErr, MemReq, Wdata, vals[i]);
      end
    end
    Valid = 1'b0;
    tick();
    checks++;
    if (WbValid !== 1'b0) begin
      errors++; $display("FAIL alu_idle: wbv=%b want 0", WbValid);
    end
  endtask

  task automatic test_byte_loads();
    logic [5:0]  ops  [2];
    logic [31:0] want [2];
    ops  = '{OP_LB, OP_LBU};
    want = '{32'hFFFFFFF2, 32'h000000F2};
    for (int k = 0; k < 2; k++) begin
      present(ops[k], 32'h1001, 32'h0);
      #1;
      checks++;
      if (Stall !== 1'b1) begin
        errors++; $display("FAIL load_stall_c0[%0d]: got %b want 1", k, Stall);
      end
      tick();
      checks++;
      if ({MemReq, MemWe, MemAddr, MemBe, WbValid} !== {1'b1, 1'b0, 32'h1000, 4'hF, 1'b0}) begin
        errors++;
        $display("FAIL load_bus[%0d]: req=%b we=%b addr=%h be=%b wbv=%b, want 1 0 00001000 1111 0",
                 k, MemReq, MemWe, MemAddr, MemBe, WbValid);
      end
      MemAck = 1'b1; MemRdata = 32'h11F23344;
      tick();
      MemAck = 1'b0;
      checks++;
      if ({WbValid, BusErr, MemReq, Stall, Wdata} !== {4'b1000, want[k]}) begin
        errors++;
        $display("FAIL load_retire[%0d]: wbv=%b berr=%b req=%b stall=%b wdata=%h, want 1 0 0 0 %h",
                 k, WbValid, BusErr, MemReq, Stall, Wdata, want[k]);
      end
      Valid = 1'b0;
      tick();
      checks++;
      if ({WbValid, Stall} !== 2'b00) begin
        errors++; $display("FAIL load_after[%0d]: wbv=%b stall=%b want 0 0", k, WbValid, Stall);
      end
    end
  endtask

  task automatic test_store_half();
    present(OP_SH, 32'h2002, 32'hABCD1234);
    #1;
    checks++;
    if (Stall !== 1'b1) begin
      errors++; $display("FAIL sh_stall_c0: got %b want 1", Stall);
    end
    for (int c = 1; c <= 3; c++) begin
      tick();
      checks++;
      if ({MemReq, MemWe, MemBe, MemWdata, MemAddr, Stall, WbValid} !==
          {1'b1, 1'b1, 4'b0011, 32'h12341234, 32'h2000, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL sh_hold_c%0d: req=%b we=%b be=%b wd=%h addr=%h stall=%b wbv=%b, want 1 1 0011 12341234 00002000 1 0",
                 c, MemReq, MemWe, MemBe, MemWdata, MemAddr, Stall, WbValid);
      end
      if (c == 3) MemAck = 1'b1;
    end
    tick();
    MemAck = 1'b0;
    checks++;
    if ({WbValid, BusErr, MemReq, Stall, Wdata} !== {4'b1000, 32'h0}) begin
      errors++;
      $display("FAIL sh_retire: wbv=%b berr=%b req=%b stall=%b wdata=%h, want 1 0 0 0 0",
               WbValid, BusErr, MemReq, Stall, Wdata);
    end
    Valid = 1'b0;
    tick();
  endtask

  task automatic test_misalign();
    present(OP_LW, 32'h3002, 32'h0);
    #1;
    checks++;
    if (Stall !== 1'b0) begin
      errors++; $display("FAIL mis_stall: got %b want 0", Stall);
    end
    tick();
    Valid = 1'b0;
    checks++;
    if ({WbValid, Misalign, BusErr, MemReq, Wdata} !== {4'b1100, 32'h0}) begin
      errors++;
      $display("FAIL mis_retire: wbv=%b mis=%b berr=%b req=%b wdata=%h, want 1 1 0 0 0",
               WbValid, Misalign, BusErr, MemReq, Wdata);
    end
    tick();
    checks++;
    if ({WbValid, Misalign, MemReq} !== 3'b000) begin
      errors++; $display("FAIL mis_after: wbv=%b mis=%b req=%b want 0", WbValid, Misalign, MemReq);
    end
  endtask

  task automatic test_timeout();
    int bad;
    present(OP_SW, 32'h5004, 32'h01020304);
    bad = 0;
    for (int c = 1; c <= TO; c++) begin
      tick();
      if ({MemReq, Stall, WbValid} !== 3'b110) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL to_req_window: %0d bad cycles in 1..%0d, want 0", bad, TO);
    end
    tick();
    checks++;
    if ({WbValid, BusErr, Misalign, MemReq, Wdata} !== {4'b1100, 32'h0}) begin
      errors++;
      $display("FAIL to_retire: wbv=%b berr=%b mis=%b req=%b wdata=%h, want 1 1 0 0 0",
               WbValid, BusErr, Misalign, MemReq, Wdata);
    end
    Valid = 1'b0;
    tick();
    MemAck = 1'b1;
    tick();
    MemAck = 1'b0;
    checks++;
    if ({WbValid, BusErr, MemReq, Stall} !== 4'b0000) begin
      errors++;
      $display("FAIL late_ack: wbv=%b berr=%b req=%b stall=%b want 0", WbValid, BusErr, MemReq, Stall);
    end
    // ack landing in the very last allowed cycle is a success
    present(OP_LW, 32'h6000, 32'h0);
    for (int c = 1; c <= TO; c++) begin
      tick();
      if (c == TO) begin MemAck = 1'b1; MemRdata = 32'h89ABCDEF; end
    end
    tick();
    MemAck = 1'b0;
    checks++;
    if ({WbValid, BusErr, MemReq, Wdata} !== {3'b100, 32'h89ABCDEF}) begin
      errors++;
      $display("FAIL ack_at_limit: wbv=%b berr=%b req=%b wdata=%h, want 1 0 0 89abcdef",
               WbValid, BusErr, MemReq, Wdata);
    end
    Valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    present(OP_LW, 32'h7000, 32'h0);
    tick();
    checks++;
    if (MemReq !== 1'b1) begin
      errors++; $display("FAIL rm_req_up: got %b want 1", MemReq);
    end
    #2;
    RST = 1'b1; Valid = 1'b0;
    #1;
    checks++;
    if ({Stall, MemReq, MemWe, MemAddr, MemBe, MemWdata, WbValid, Wdata, Misalign, BusErr} !== '0) begin
      errors++;
      $display("FAIL rm_async: req=%b we=%b addr=%h be=%b wbv=%b stall=%b, want all 0",
               MemReq, MemWe, MemAddr, MemBe, WbValid, Stall);
    end
    tick(); tick();
    RST = 1'b0;
    tick();
    checks++;
    if ({WbValid, MemReq} !== 2'b00) begin
      errors++; $display("FAIL rm_no_retire: wbv=%b req=%b want 0", WbValid, MemReq);
    end
    present(OP_LW, 32'h8004, 32'h0);
    tick();
    checks++;
    if ({MemReq, MemAddr} !== {1'b1, 32'h8004}) begin
      errors++; $display("FAIL rm_lw_bus: req=%b addr=%h want 1 00008004", MemReq, MemAddr);
    end
    MemAck = 1'b1; MemRdata = 32'hCAFEBABE;
    tick();
    MemAck = 1'b0;
    checks++;
    if ({WbValid, BusErr, Wdata} !== {2'b10, 32'hCAFEBABE}) begin
      errors++; $display("FAIL rm_lw_retire: wbv=%b berr=%b wdata=%h want 1 0 cafebabe", WbValid, BusErr, Wdata);
    end
    Valid = 1'b0;
    tick();
  endtask

  task automatic test_random();
    logic [5:0]  mem_ops [8];
    logic [5:0]  op;
    logic [31:0] res, d2, rd, r, want;
    int          off, ackd, c;
    bit          mem, mis, got;
    mem_ops = '{OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW};
    for (int n = 0; n < 150; n++) begin
      r = $urandom;
      if (r % 12 < 8) op = mem_ops[r % 8];
      else begin
        op = 6'(r >> 8);
        while (m_is_mem(op)) op = op + 6'd1;
      end
      res = $urandom;
      if (r[20]) res[1:0] = 2'b00;
      d2  = $urandom;
      off = int'(res[1:0]);
      mem = m_is_mem(op);
      mis = m_mis(op, off);
      present(op, res, d2);
      r = $urandom;
      MemAck   = r[0];
      MemRdata = $urandom;
      #1;
      checks++;
      if (Stall !== (mem && !mis)) begin
        errors++; $display("FAIL rnd_stall[%0d]: op=%h res=%h got %b want %b", n, op, res, Stall, mem && !mis);
      end
      if (!mem || mis) begin
        tick();
        want = mis ? 32'h0 : res;
        checks++;
        if ({WbValid, Misalign, BusErr, MemReq, Wdata} !== {1'b1, mis, 2'b00, want}) begin
          errors++;
          $display("FAIL rnd_fast[%0d]: op=%h wbv=%b mis=%b berr=%b req=%b wdata=%h, want 1 %b 0 0 %h",
                   n, op, WbValid, Misalign, BusErr, MemReq, Wdata, mis, want);
        end
      end else begin
        r = $urandom_range(0, 19);
        ackd = (r == 0) ? -1 : (r == 1) ? TO - 1 : int'($urandom_range(0, 3));
        got = 1'b0;
        c = 0;
        rd = 32'h0;
        while (!got && c < TO) begin
          tick();
          c++;
          MemAck = 1'b0;
          MemRdata = $urandom;
          checks++;
          if ({MemReq, MemWe, MemAddr, MemBe, Stall, WbValid} !==
              {1'b1, m_is_store(op), {res[31:2], 2'b00}, m_be(op, off), 1'b1, 1'b0} ||
              (m_is_store(op) && MemWdata !== m_wd(op, d2))) begin
            errors++;
            $display("FAIL rnd_bus[%0d]: op=%h c=%0d req=%b we=%b addr=%h be=%b wd=%h, want we=%b addr=%h be=%b wd=%h",
                     n, op, c, MemReq, MemWe, MemAddr, MemBe, MemWdata, m_is_store(op),
                     {res[31:2], 2'b00}, m_be(op, off), m_wd(op, d2));
          end
          if (c - 1 == ackd) begin
            rd = $urandom;
            MemRdata = rd;
            MemAck = 1'b1;
            got = 1'b1;
          end
        end
        tick();
        MemAck = 1'b0;
        want = (got && !m_is_store(op)) ? m_ld(op, off, rd) : 32'h0;
        checks++;
        if ({WbValid, Misalign, BusErr, MemReq, Stall, Wdata} !== {2'b10, !got, 2'b00, want}) begin
          errors++;
          $display("FAIL rnd_retire[%0d]: op=%h off=%0d rd=%h wbv=%b berr=%b req=%b stall=%b wdata=%h, want 1 %b 0 0 %h",
                   n, op, off, rd, WbValid, BusErr, MemReq, Stall, Wdata, !got, want);
        end
        tick();
        checks++;
        if ({WbValid, MemReq} !== 2'b00) begin
          errors++; $display("FAIL rnd_gap[%0d]: wbv=%b req=%b want 0 0", n, WbValid, MemReq);
        end
      end
    end
    Valid = 1'b0;
    MemAck = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_alu_stream();
    test_byte_loads();
    test_store_half();
    test_misalign();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
